// File: rtl/stopwatch_pkg.sv
// Shared state encoding, default sizing and counter-width helper for the stopwatch block.
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_LAP   = 2'd3;

    localparam int unsigned DEF_MAXVAL   = 999;
    localparam int unsigned DEF_PRESCALE = 4;

    // Bits needed to hold 0..mod-1, never less than one.
    function automatic int unsigned cnt_w(input int unsigned mod);
        return (mod > 1) ? $clog2(mod) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Command pulses from the button logic and display-side status of the stopwatch.
interface stopwatch_ctrl_if;

    logic        start;
    logic        stop;
    logic        lap;
    logic        clear;
    logic [31:0] out;
    logic [31:0] live;
    logic        run;
    logic        lapped;
    logic        wrap;

    modport master (
        output start, stop, lap, clear,
        input  out, live, run, lapped, wrap
    );

    modport slave (
        input  start, stop, lap, clear,
        output out, live, run, lapped, wrap
    );

endinterface

// File: rtl/stopwatch_ctrl_mod_counter.sv
// Modulo-MOD up counter with synchronous clear; tc flags the wrapping increment.
module mod_counter
    import stopwatch_pkg::*;
#(
    parameter  int unsigned MOD = 4,
    localparam int unsigned W   = cnt_w(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         sclr,
    output logic [W-1:0] q,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] q_q, q_d;

    assign tc = en && (q_q == LAST);
    assign q  = q_q;

    always_comb begin
        q_d = q_q;
        if (sclr)
            q_d = '0;
        else if (tc)
            q_d = '0;
        else if (en)
            q_d = q_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q_q <= '0;
        else
            q_q <= q_d;
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: command FSM gating a prescaler and a mod-(MAXVAL+1) value
// counter, with a lap snapshot that freezes the displayed value.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAXVAL   = DEF_MAXVAL,
    parameter int unsigned PRESCALE = DEF_PRESCALE
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_ctrl_if.slave  bus
);

    localparam int unsigned VW = cnt_w(MAXVAL + 1);
    localparam int unsigned PW = cnt_w(PRESCALE);

    logic [1:0]    state_q, state_d;
    logic [VW-1:0] snap_q, snap_d;
    logic [VW-1:0] out_q, out_d;
    logic          run_q, run_d;
    logic          lapped_q, lapped_d;
    logic          wrap_q, wrap_d;

    logic [VW-1:0] live_cnt, live_nxt;
    logic [PW-1:0] pre_cnt;
    logic          pre_tc, val_tc, running;
    logic          do_clear, do_stop, do_start, do_lap;

    // Only the highest-priority asserted command is decoded; lower ones are dropped.
    assign do_clear = bus.clear;
    assign do_stop  = !bus.clear && bus.stop;
    assign do_start = !bus.clear && !bus.stop && bus.start;
    assign do_lap   = !bus.clear && !bus.stop && !bus.start && bus.lap;

    assign running = (state_q == ST_RUN) || (state_q == ST_LAP);

    mod_counter #(.MOD(PRESCALE)) u_pre (
        .clk  (clk),
        .rst  (rst),
        .en   (running),
        .sclr (do_clear || (state_q == ST_IDLE && do_start)),
        .q    (pre_cnt),
        .tc   (pre_tc)
    );

    mod_counter #(.MOD(MAXVAL + 1)) u_val (
        .clk  (clk),
        .rst  (rst),
        .en   (pre_tc),
        .sclr (do_clear),
        .q    (live_cnt),
        .tc   (val_tc)
    );

    always_comb begin
        state_d = state_q;
        if (do_clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (do_start) state_d = ST_RUN;
                ST_RUN:   if (do_stop) state_d = ST_PAUSE;
                          else if (do_lap) state_d = ST_LAP;
                ST_PAUSE: if (do_start) state_d = ST_RUN;
                ST_LAP:   if (do_stop) state_d = ST_PAUSE;
                          else if (do_lap) state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Post-edge value of the counter, so the registered display can follow it.
    always_comb begin
        live_nxt = live_cnt;
        if (do_clear || val_tc)
            live_nxt = '0;
        else if (pre_tc)
            live_nxt = live_cnt + 1'b1;
    end

    always_comb begin
        snap_d = snap_q;
        if (state_q == ST_RUN && state_d == ST_LAP)
            snap_d = live_cnt;
        out_d    = (state_d == ST_LAP) ? snap_d : live_nxt;
        run_d    = (state_d == ST_RUN) || (state_d == ST_LAP);
        lapped_d = (state_d == ST_LAP);
        wrap_d   = val_tc && !do_clear;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            snap_q   <= '0;
            out_q    <= '0;
            run_q    <= 1'b0;
            lapped_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            out_q    <= out_d;
            run_q    <= run_d;
            lapped_q <= lapped_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bus.out    = 32'(out_q);
    assign bus.live   = 32'(live_cnt);
    assign bus.run    = run_q;
    assign bus.lapped = lapped_q;
    assign bus.wrap   = wrap_q;

endmodule
